// File: rtl/fft_frame_arbiter.sv
// Round-robin frame arbiter that shares one FFT + tone-detector datapath between two sample sources.
// Optional watchdog is built when FFT_FRAME_ARBITER_TIMEOUT_EN is defined.
module fft_frame_arbiter #(
   parameter int N_SAMPLES = 128,
   parameter int CE_GAP    = 4,
   parameter int TIMEOUT   = 4096
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        s0_req,
   input  logic        s1_req,
   input  logic        s0_valid,
   input  logic        s1_valid,
   input  logic [15:0] s0_data,
   input  logic [15:0] s1_data,
   output logic        s0_ready,
   output logic        s1_ready,
   output logic        fft_ce,
   output logic [15:0] fft_sample,
   output logic        fft_rst,
   input  logic        fft_sync,
   output logic        td_rst_n,
   output logic        td_en,
   input  logic        td_done,
   input  logic [15:0] td_tone,
   output logic        res_valid,
   output logic        res_owner,
   output logic [15:0] res_tone,
   input  logic        res_ack,
   output logic        busy,
   output logic        err,
   input  logic        err_clr,
   output logic [6:0]  sample_idx,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PREP   = 3'd1,
      LOAD   = 3'd2,
      GAP    = 3'd3,
      FLUSH  = 3'd4,
      RESULT = 3'd5,
      ERROR  = 3'd6
   } state_t;

   localparam int GAP_W = $clog2(CE_GAP);

   state_t           state_q;
   logic             owner_q;
   logic             lastOwner_q;
   logic             lastSample_q;
   logic [GAP_W-1:0] gapCnt_q;
   logic [6:0]       sampleIdx_q;
   logic             fftCe_q;
   logic [15:0]      fftSample_q;
   logic             fftRst_q;
   logic             tdRstN_q;
   logic             tdEn_q;
   logic             resValid_q;
   logic             resOwner_q;
   logic [15:0]      resTone_q;
   logic             busy_q;

   logic             grantOwner_d;
   logic             curValid;
   logic [15:0]      curData;
   logic             accept;
   logic             gapDone;
   logic             flushEntry;

   assign s0_ready     = (state_q == LOAD) && !owner_q;
   assign s1_ready     = (state_q == LOAD) && owner_q;
   assign curValid     = owner_q ? s1_valid : s0_valid;
   assign curData      = owner_q ? s1_data : s0_data;
   assign accept       = (state_q == LOAD) && curValid;
   assign gapDone      = (gapCnt_q == GAP_W'(CE_GAP - 1));
   assign flushEntry   = (state_q == GAP) && gapDone && lastSample_q;
   // On a tie the source that did not own the previous frame wins
   assign grantOwner_d = (s0_req && s1_req) ? !lastOwner_q : s1_req;

`ifdef FFT_FRAME_ARBITER_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT);

   logic [WD_W-1:0] wdCnt_q;
   logic            err_q;
   logic            inWatch;
   logic            wdTrip;

   assign inWatch = (state_q == LOAD) || (state_q == GAP) || (state_q == FLUSH);
   // A completing td_done, a sample accept or the move into FLUSH all pre-empt the watchdog
   assign wdTrip  = (wdCnt_q == WD_W'(TIMEOUT - 1)) &&
                    (((state_q == LOAD) && !accept) ||
                     ((state_q == GAP) && !flushEntry) ||
                     ((state_q == FLUSH) && !td_done));
   assign err     = err_q;

   always_ff @(posedge clk) begin
      if (!reset_n || !inWatch || accept || flushEntry) begin
         wdCnt_q <= '0;
      end else begin
         wdCnt_q <= wdCnt_q + 1'b1;
      end
   end
`else
   logic unusedErrClr;

   assign unusedErrClr = err_clr | (TIMEOUT == 0);
   assign err          = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         lastOwner_q  <= 1'b1;
         lastSample_q <= 1'b0;
         gapCnt_q     <= '0;
         sampleIdx_q  <= '0;
         fftCe_q      <= 1'b0;
         fftSample_q  <= '0;
         fftRst_q     <= 1'b1;
         tdRstN_q     <= 1'b0;
         tdEn_q       <= 1'b0;
         resValid_q   <= 1'b0;
         resOwner_q   <= 1'b0;
         resTone_q    <= '0;
         busy_q       <= 1'b0;
`ifdef FFT_FRAME_ARBITER_TIMEOUT_EN
         err_q        <= 1'b0;
      end else if (wdTrip) begin
         state_q      <= ERROR;
         err_q        <= 1'b1;
         fftRst_q     <= 1'b1;
         tdRstN_q     <= 1'b0;
         tdEn_q       <= 1'b0;
         fftCe_q      <= 1'b0;
         busy_q       <= 1'b0;
`endif
      end else begin
         fftCe_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (s0_req || s1_req) begin
                  owner_q      <= grantOwner_d;
                  fftRst_q     <= 1'b0;
                  tdRstN_q     <= 1'b1;
                  busy_q       <= 1'b1;
                  sampleIdx_q  <= '0;
                  lastSample_q <= 1'b0;
                  state_q      <= PREP;
               end
            end
            PREP: state_q <= LOAD;
            LOAD: begin
               if (accept) begin
                  fftSample_q  <= curData;
                  fftCe_q      <= 1'b1;
                  sampleIdx_q  <= sampleIdx_q + 1'b1;
                  // sample_idx wraps at 128, so completion is remembered separately
                  lastSample_q <= (sampleIdx_q == 7'(N_SAMPLES - 1));
                  gapCnt_q     <= GAP_W'(1);
                  state_q      <= GAP;
               end
            end
            GAP: begin
               if (gapDone) begin
                  gapCnt_q <= '0;
                  if (lastSample_q) begin
                     fftSample_q <= '0;
                     state_q     <= FLUSH;
                  end else begin
                     state_q <= LOAD;
                  end
               end else begin
                  gapCnt_q <= gapCnt_q + 1'b1;
               end
            end
            FLUSH: begin
               fftSample_q <= '0;
               if (td_done) begin
                  resTone_q  <= td_tone;
                  resOwner_q <= owner_q;
                  resValid_q <= 1'b1;
                  tdEn_q     <= 1'b0;
                  busy_q     <= 1'b0;
                  state_q    <= RESULT;
               end else begin
                  if (fft_sync) begin
                     tdEn_q <= 1'b1;
                  end
                  fftCe_q  <= (gapCnt_q == '0);
                  gapCnt_q <= gapDone ? '0 : gapCnt_q + 1'b1;
               end
            end
            RESULT: begin
               if (res_ack) begin
                  resValid_q  <= 1'b0;
                  lastOwner_q <= owner_q;
                  fftRst_q    <= 1'b1;
                  tdRstN_q    <= 1'b0;
                  state_q     <= IDLE;
               end
            end
`ifdef FFT_FRAME_ARBITER_TIMEOUT_EN
            ERROR: begin
               if (err_clr) begin
                  err_q       <= 1'b0;
                  lastOwner_q <= owner_q;
                  state_q     <= IDLE;
               end
            end
`endif
            default: state_q <= IDLE;
         endcase
      end
   end

   assign fft_ce     = fftCe_q;
   assign fft_sample = fftSample_q;
   assign fft_rst    = fftRst_q;
   assign td_rst_n   = tdRstN_q;
   assign td_en      = tdEn_q;
   assign res_valid  = resValid_q;
   assign res_owner  = resOwner_q;
   assign res_tone   = resTone_q;
   assign busy       = busy_q;
   assign sample_idx = sampleIdx_q;
   assign state_dbg  = state_q;

endmodule

// File: doc/fft_frame_arbiter.md
Name: fft_frame_arbiter

Overview:
- Shares the single FFT plus tone-detector datapath between two sample sources: source 0 is the MCU/I2C sample path, source 1 is a local ADC capture path.
- Grants the datapath one whole frame at a time, using round-robin between the sources.
- Paces the FFT chip-enable pulses, runs the flush phase after the last sample, waits for the tone detector and returns the tone tagged with the owning source.
- Sits between the I2C register/control logic and the FFT/tone-detector instances.

Parameters:
- N_SAMPLES, 128, samples per frame; must be a power of 2, at most 128.
- CE_GAP, 4, clocks from one fft_ce pulse to the next; minimum 2.
- TIMEOUT, 4096, watchdog limit in clocks (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  reset.
- s0_req, s1_req  in  1 each  source requests a frame.
- s0_valid, s1_valid  in  1 each  sample valid.
- s0_data, s1_data  in  16 each  sample, two's complement.
- s0_ready, s1_ready  out  1 each  sample accepted this cycle.
- fft_ce  out  1  FFT clock-enable pulse.
- fft_sample  out  16  FFT input sample.
- fft_rst  out  1  FFT reset, active high.
- fft_sync  in  1  FFT first-output marker.
- td_rst_n  out  1  tone-detector reset, active low.
- td_en  out  1  tone-detector enable.
- td_done  in  1  tone detection complete.
- td_tone  in  16  detected tone.
- res_valid  out  1  result available.
- res_owner  out  1  source that owns the result.
- res_tone  out  16  captured tone.
- res_ack  in  1  result consumed.
- busy  out  1  frame in progress.
- err  out  1  watchdog error.
- err_clr  in  1  leave the error state.
- sample_idx  out  7  index of the next sample expected.
- state_dbg  out  3  present state.

Behaviour:
- Reset is on reset_n, synchronous, active-low. It is sampled on the rising clk edge and takes priority over everything, including mid-frame.
- Reset values:
  - state = IDLE, fft_rst = 1, td_rst_n = 0.
  - fft_ce, td_en, res_valid, busy, err = 0.
  - fft_sample, res_tone, sample_idx = 0.
  - res_owner = 0; last_owner = 1, so source 0 wins the first tie.
- Encodings: IDLE=0, PREP=1, LOAD=2, GAP=3, FLUSH=4, RESULT=5, ERROR=6.
- IDLE:
  - fft_rst = 1, td_rst_n = 0, busy = 0.
  - With a single request, grant that source.
  - With both requests, grant the source that is not last_owner.
  - On grant: latch owner, go to PREP.
- PREP (one cycle): fft_rst = 0, td_rst_n = 1, sample_idx = 0, busy = 1, then go to LOAD.
- LOAD:
  - sN_ready = 1 combinationally, only for the granted source.
  - On valid && ready: register fft_sample = data and fft_ce = 1 for exactly one cycle (the next one), increment sample_idx, go to GAP.
  - The non-granted source always sees ready = 0.
- GAP:
  - Waits until the fft_ce pulse spacing reaches CE_GAP clocks.
  - Then, if sample_idx == N_SAMPLES (counter wraps to 0 when N = 128; track completion with a separate flag), go to FLUSH with the gap counter cleared; otherwise go to LOAD.
- FLUSH:
  - fft_sample = 0; one fft_ce pulse every CE_GAP clocks, continuously.
  - fft_sync high on any cycle: td_en = 1 from the next cycle, sticky until RESULT.
  - td_done: res_tone = td_tone, res_owner = owner, res_valid = 1, td_en = 0, go to RESULT.
  - td_done arriving before sync is still accepted.
- RESULT:
  - No fft_ce pulses; busy = 0.
  - On res_ack: res_valid = 0, last_owner = owner, go to IDLE. New requests are arbitrated on the following cycle.
  - res_tone holds its value until the next capture.
- Request withdrawal: a source dropping its req mid-frame has no effect; the frame completes.
- Latency: first fft_ce pulse 3 cycles after the grant edge (IDLE → PREP → LOAD, then accept).

Optional Feature:
- Macro: FFT_FRAME_ARBITER_TIMEOUT_EN.
- Enabled:
  - A watchdog counts clocks spent in LOAD, GAP and FLUSH; it clears on every sample accept and on entry to FLUSH.
  - Reaching TIMEOUT goes to ERROR: err = 1, fft_rst = 1, td_rst_n = 0, td_en = 0, fft_ce = 0.
  - err_clr in ERROR: err = 0, last_owner = owner, go to IDLE.
  - td_done and timeout in the same cycle: td_done wins.
- Disabled: no watchdog, ERROR is unreachable, err is tied to 0, err_clr is ignored.

Test Plan:
- Reset, then s0_req=1 with 128 valid samples 0..127 and CE_GAP=4 → 128 single-cycle fft_ce pulses spaced 4 clocks apart, fft_sample matches each sample, s1_ready stays 0, then flush pulses begin.
- In FLUSH, pulse fft_sync, then td_done with td_tone=16'h0A3C 10 clocks later → td_en rises the cycle after sync; res_valid=1, res_owner=0, res_tone=16'h0A3C; busy=0.
- s0_req and s1_req both held through two frames with res_ack each time → grants go 0 then 1; res_owner 0 then 1.
- s0_valid withheld for 4096 clocks after sample 5 (macro on) → err=1, state_dbg=6, fft_rst=1; err_clr → IDLE next cycle, err=0.
- reset_n=0 for one clock at sample 60 → next cycle all outputs at reset values, sample_idx=0, state_dbg=0.
- td_done and timeout in the same cycle (macro on) → RESULT entered, err=0.
